// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate, ping-pong and bar-fill patterns advanced on a
// scaled tick, with registered PWM brightness gating on the LED outputs.
module led_pattern_gen #(
    parameter int LED_NUM  = 4,
    parameter int TICK_CNT = 5000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode,
    input  logic [1:0]         speed,
    input  logic               pause,
    input  logic [3:0]         brightness,
    output logic [LED_NUM-1:0] led,
    output logic               step_pulse,
    output logic [1:0]         dbg_mode
);

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'b00,
        MODE_ROT_R = 2'b01,
        MODE_PING  = 2'b10,
        MODE_FILL  = 2'b11
    } mode_e;

    localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam int IW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int LW = $clog2(LED_NUM + 1);
    localparam logic [TW-1:0]      TICK_MAX = TW'(TICK_CNT - 1);
    localparam logic [IW-1:0]      IDX_MAX  = IW'(LED_NUM - 1);
    localparam logic [LW-1:0]      LVL_MAX  = LW'(LED_NUM);
    localparam logic [LED_NUM-1:0] START    = LED_NUM'(1);

    logic [TW-1:0]      tick_cnt;
    logic [2:0]         step_cnt;
    logic [3:0]         pwm_cnt;
    mode_e              mode_q, mode_d;
    logic [LED_NUM-1:0] pattern, pattern_d;
    logic [LED_NUM-1:0] rot_l, rot_r;
    logic [IW-1:0]      pp_idx, idx_d;
    logic               pp_up, up_d;
    logic [LW-1:0]      fill_lvl, lvl_d;
    logic [2:0]         step_max;
    logic               base_tick;
    logic               step_evt;
    logic               pwm_on;

    assign base_tick = !pause && (tick_cnt == TICK_MAX);
    assign pwm_on    = (pwm_cnt < brightness);
    assign dbg_mode  = mode_q;

    always_comb begin
        step_max = 3'd0;
        case (speed)
            2'd0: step_max = 3'd0;
            2'd1: step_max = 3'd1;
            2'd2: step_max = 3'd3;
            default: step_max = 3'd7;
        endcase
    end

    // ">=" rather than "==" so a speed reduction past the current count steps at once
    assign step_evt = base_tick && (step_cnt >= step_max);

    always_comb begin
        rot_l = '0;
        rot_r = '0;
        for (int i = 0; i < LED_NUM; i++) begin
            rot_l[i] = pattern[(i + LED_NUM - 1) % LED_NUM];
            rot_r[i] = pattern[(i + 1) % LED_NUM];
        end
    end

    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern;
        idx_d     = pp_idx;
        up_d      = pp_up;
        lvl_d     = fill_lvl;
        if (step_evt) begin
            if (mode_e'(mode) != mode_q) begin
                mode_d    = mode_e'(mode);
                pattern_d = START;
                idx_d     = '0;
                up_d      = 1'b1;
                lvl_d     = LW'(1);
            end else begin
                case (mode_q)
                    MODE_ROT_L: pattern_d = rot_l;
                    MODE_ROT_R: pattern_d = rot_r;
                    MODE_PING: begin
                        // Endpoints are visited once: turn around on the step that leaves them
                        if (pp_up) begin
                            if (pp_idx == IDX_MAX) begin
                                if (LED_NUM > 1) begin
                                    idx_d = pp_idx - IW'(1);
                                    up_d  = 1'b0;
                                end
                            end else begin
                                idx_d = pp_idx + IW'(1);
                            end
                        end else begin
                            if (pp_idx == '0) begin
                                idx_d = pp_idx + IW'(1);
                                up_d  = 1'b1;
                            end else begin
                                idx_d = pp_idx - IW'(1);
                            end
                        end
                        for (int i = 0; i < LED_NUM; i++) begin
                            pattern_d[i] = (IW'(i) == idx_d);
                        end
                    end
                    default: begin
                        lvl_d = (fill_lvl == LVL_MAX) ? '0 : fill_lvl + LW'(1);
                        for (int i = 0; i < LED_NUM; i++) begin
                            pattern_d[i] = (LW'(i) < lvl_d);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt   <= '0;
            step_cnt   <= '0;
            pwm_cnt    <= '0;
            mode_q     <= MODE_ROT_L;
            pattern    <= START;
            pp_idx     <= '0;
            pp_up      <= 1'b1;
            fill_lvl   <= LW'(1);
            step_pulse <= 1'b0;
            led        <= '0;
        end else begin
            if (!pause) begin
                tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
                pwm_cnt  <= (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;
                if (base_tick) begin
                    step_cnt <= step_evt ? 3'd0 : step_cnt + 3'd1;
                end
            end
            mode_q     <= mode_d;
            pattern    <= pattern_d;
            pp_idx     <= idx_d;
            pp_up      <= up_d;
            fill_lvl   <= lvl_d;
            step_pulse <= step_evt;
            led        <= pattern & {LED_NUM{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_CNT=4, LED_NUM=4: step timing,
// every pattern mode, mode switching, speed and pause, PWM duty and async reset.
module tb_led_pattern_gen;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic [1:0] mode       = 2'd0;
    logic [1:0] speed      = 2'd0;
    logic       pause      = 1'b0;
    logic [3:0] brightness = 4'd15;
    logic [3:0] led;
    logic       step_pulse;
    logic [1:0] dbg_mode;

    int total = 0;
    int bad   = 0;
    int since = 0;

    led_pattern_gen #(.LED_NUM(4), .TICK_CNT(4)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .mode       (mode),
        .speed      (speed),
        .pause      (pause),
        .brightness (brightness),
        .led        (led),
        .step_pulse (step_pulse),
        .dbg_mode   (dbg_mode)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            since++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // since = active edges since the previous step edge (or reset release)
    task automatic next_step(input string tag, input int gap, input logic [3:0] exp_led);
        while (step_pulse !== 1'b1 && since < 64) cyc(1);
        check({tag, "_gap"}, since, gap);
        since = 0;
        cyc(1);
        check({tag, "_pulse_width"}, {31'b0, step_pulse}, 32'd0);
        check({tag, "_led"}, {28'b0, led}, {28'b0, exp_led});
    endtask

    logic [3:0] pp_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] bf_exp [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001};
    int on_cnt;
    int other_cnt;

    initial begin
        cyc(3);
        check("rst_led", {28'b0, led}, 32'd0);
        check("rst_pulse", {31'b0, step_pulse}, 32'd0);
        check("rst_mode", {30'b0, dbg_mode}, 32'd0);

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        since = 0;
        cyc(1);
        check("rel_led", {28'b0, led}, 32'h1);

        next_step("rl1", 4, 4'b0010);
        next_step("rl2", 4, 4'b0100);
        next_step("rl3", 4, 4'b1000);
        next_step("rl4", 4, 4'b0001);

        mode = 2'd2;
        next_step("pp_reload", 4, 4'b0001);
        check("pp_mode", {30'b0, dbg_mode}, 32'd2);
        for (int i = 0; i < 7; i++) next_step($sformatf("pp%0d", i), 4, pp_exp[i]);

        mode = 2'd3;
        next_step("bf_reload", 4, 4'b0001);
        for (int i = 0; i < 5; i++) next_step($sformatf("bf%0d", i), 4, bf_exp[i]);

        mode = 2'd0;
        next_step("rl_reload", 4, 4'b0001);
        next_step("rl5", 4, 4'b0010);

        cyc(2);
        mode = 2'd1;
        check("mid_hold", {28'b0, led}, 32'h2);
        next_step("rr_reload", 4, 4'b0001);
        next_step("rr1", 4, 4'b1000);
        next_step("rr2", 4, 4'b0100);

        speed = 2'd2;
        next_step("spd2", 16, 4'b0010);

        cyc(3);
        pause = 1'b1;
        cyc(10);
        check("pause_led", {28'b0, led}, 32'h2);
        check("pause_pulse", {31'b0, step_pulse}, 32'd0);
        pause = 1'b0;
        next_step("pause", 26, 4'b0001);

        cyc(8);
        speed = 2'd1;
        next_step("spd_shrink", 12, 4'b1000);
        next_step("spd1", 8, 4'b0100);

        speed = 2'd0;
        next_step("spd0a", 4, 4'b0010);
        next_step("spd0b", 4, 4'b0001);

        speed = 2'd3;
        brightness = 4'd5;
        cyc(1);
        on_cnt = 0;
        other_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (led[0]) on_cnt++;
            if (led[3:1] != 3'b000) other_cnt++;
            cyc(1);
        end
        check("bright5_on", on_cnt, 32'd5);
        check("bright5_other", other_cnt, 32'd0);

        brightness = 4'd0;
        cyc(1);
        on_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (led != 4'b0000) on_cnt++;
            cyc(1);
        end
        check("bright0_lit", on_cnt, 32'd0);

        brightness = 4'd15;
        cyc(2);
        check("pre_rst_led", {28'b0, led}, 32'h8);

        #2;
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_led", {28'b0, led}, 32'd0);
        check("async_rst_pulse", {31'b0, step_pulse}, 32'd0);
        check("async_rst_mode", {30'b0, dbg_mode}, 32'd0);

        mode = 2'd0;
        speed = 2'd0;
        cyc(2);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        since = 0;
        cyc(1);
        check("rerel_led", {28'b0, led}, 32'h1);
        next_step("post_rst", 4, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
